// File: rtl/alu_pkg.sv
// Shared constants and flag-update encodings for the ALU operand path.
package alu_pkg;

  localparam int WIDTH = 8;
  localparam int AW    = 3;
  localparam int NREGS = 1 << AW;

  typedef enum logic [1:0] {
    FLAG_HOLD  = 2'b00,
    FLAG_LOAD  = 2'b01,
    FLAG_CLR_C = 2'b10,
    FLAG_SET_C = 2'b11
  } flag_op_t;

endpackage

// File: rtl/alu_flag_reg.sv
// Carry/zero status register with flag_op decode; carry feeds back to ALU carry_in.
module alu_flag_reg
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] flag_op,
  input  logic       alu_zero,
  input  logic       alu_carry,
  output logic       carry_flag,
  output logic       zero_flag
);

  flag_op_t op;
  logic     carry_reg, carry_next;
  logic     zero_reg, zero_next;

  assign op = flag_op_t'(flag_op);

  always_comb begin
    carry_next = carry_reg;
    zero_next  = zero_reg;
    if (en) begin
      unique case (op)
        FLAG_HOLD:  ;
        FLAG_LOAD:  begin
          carry_next = alu_carry;
          zero_next  = alu_zero;
        end
        FLAG_CLR_C: carry_next = 1'b0;
        FLAG_SET_C: carry_next = 1'b1;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_reg <= 1'b0;
      zero_reg  <= 1'b0;
    end else begin
      carry_reg <= carry_next;
      zero_reg  <= zero_next;
    end
  end

  assign carry_flag = carry_reg;
  assign zero_flag  = zero_reg;

endmodule

// File: rtl/alu_operand_file.sv
// Register file (r0 hardwired to zero) with two combinational read ports and
// one write port, plus the carry/zero flag register in front of the ALU.
module alu_operand_file #(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int NREGS = alu_pkg::NREGS,
  parameter int AW    = alu_pkg::AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    ra_addr,
  input  logic [AW-1:0]    rb_addr,
  output logic [WIDTH-1:0] a_data,
  output logic [WIDTH-1:0] b_data,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [1:0]       flag_op,
  input  logic             alu_zero,
  input  logic             alu_carry,
  output logic             carry_flag,
  output logic             zero_flag
);

  import alu_pkg::*;

  // Stays low through the first edge after reset release so that any write or
  // flag update landing on that edge is dropped regardless of edge ordering.
  logic run_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_reg <= 1'b0;
    else        run_reg <= 1'b1;
  end

  logic [NREGS-1:0][WIDTH-1:0] rf;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign rf[gi] = '0;
      end else begin : g_store
        logic [WIDTH-1:0] r_reg;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)
            r_reg <= '0;
          else if (run_reg && wr_en && (wr_addr == AW'(gi)))
            r_reg <= wr_data;
        end
        assign rf[gi] = r_reg;
      end
    end
  endgenerate

  // No bypass: wr_data comes from the ALU, which is fed by these ports.
  assign a_data = rf[ra_addr];
  assign b_data = rf[rb_addr];

  alu_flag_reg u_flags (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (run_reg),
    .flag_op    (flag_op),
    .alu_zero   (alu_zero),
    .alu_carry  (alu_carry),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag)
  );

endmodule

// File: tb/tb_alu_operand_file.sv
// Directed scoreboard bench for alu_operand_file.
module tb_alu_operand_file;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] ra_addr, rb_addr, wr_addr;
  logic [7:0] a_data, b_data, wr_data;
  logic       wr_en, alu_zero, alu_carry, carry_flag, zero_flag;
  logic [1:0] flag_op;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic       z;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alu_operand_file dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ra_addr    (ra_addr),
    .rb_addr    (rb_addr),
    .a_data     (a_data),
    .b_data     (b_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .flag_op    (flag_op),
    .alu_zero   (alu_zero),
    .alu_carry  (alu_carry),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag)
  );

  task automatic push(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic c, input logic z);
    exp_t e;
    e.tag = tag; e.a = a; e.b = b; e.c = c; e.z = z;
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pops the oldest expectation and compares it with what the DUT shows now.
  task automatic observe();
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=none expected=entry");
    end else begin
      e = sb.pop_front();
      $display("t=%0t %s ra=%0d rb=%0d a=%h b=%h c=%b z=%b", $time, e.tag,
               ra_addr, rb_addr, a_data, b_data, carry_flag, zero_flag);
      chk({e.tag, ".a"}, a_data, e.a);
      chk({e.tag, ".b"}, b_data, e.b);
      chk({e.tag, ".c"}, {7'b0, carry_flag}, {7'b0, e.c});
      chk({e.tag, ".z"}, {7'b0, zero_flag}, {7'b0, e.z});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; flag_op = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0; ra_addr = 0; rb_addr = 0; wr_addr = 0; wr_data = 0;
    wr_en = 0; flag_op = 0; alu_zero = 0; alu_carry = 0;

    // Reset held: every address reads zero
    #2;
    for (int i = 0; i < 8; i++) begin
      ra_addr = 3'(i); rb_addr = 3'(7 - i);
      push("reset_hold", 8'h00, 8'h00, 1'b0, 1'b0);
      observe();
    end

    // Release between edges; write and flag set on the release edge are dropped
    @(negedge clk);
    rst_n = 1'b1;
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h5A; flag_op = 2'b11;
    ra_addr = 3'd1; rb_addr = 3'd1;
    step();
    idle();
    push("release_edge_drop", 8'h00, 8'h00, 1'b0, 1'b0);
    observe();

    // Write/read, visible only after the edge
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hE5; ra_addr = 3'd3; rb_addr = 3'd5;
    push("wr3_before", 8'h00, 8'h00, 1'b0, 1'b0);
    observe();
    step();
    wr_addr = 3'd5; wr_data = 8'hC7;
    push("wr3_after_wr5_before", 8'hE5, 8'h00, 1'b0, 1'b0);
    observe();
    step();
    idle();
    push("wr5_after", 8'hE5, 8'hC7, 1'b0, 1'b0);
    observe();

    // r0 is read-only zero
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hFF; ra_addr = 3'd0; rb_addr = 3'd0;
    step();
    idle();
    push("r0_protect", 8'h00, 8'h00, 1'b0, 1'b0);
    observe();

    // Read during write returns old value until the edge
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h11;
    step();
    wr_data = 8'h22; ra_addr = 3'd2; rb_addr = 3'd2;
    push("rdw_before", 8'h11, 8'h11, 1'b0, 1'b0);
    observe();
    step();
    idle();
    push("rdw_after", 8'h22, 8'h22, 1'b0, 1'b0);
    observe();

    // Flag operations
    flag_op = 2'b01; alu_carry = 1'b1; alu_zero = 1'b1;
    step();
    idle();
    push("flag_load_c1z1", 8'h22, 8'h22, 1'b1, 1'b1);
    observe();
    flag_op = 2'b10; alu_carry = 1'b1; alu_zero = 1'b0;
    step();
    idle();
    push("flag_clr_c", 8'h22, 8'h22, 1'b0, 1'b1);
    observe();
    flag_op = 2'b11; alu_carry = 1'b0;
    step();
    idle();
    push("flag_set_c", 8'h22, 8'h22, 1'b1, 1'b1);
    observe();
    flag_op = 2'b00;
    for (int i = 0; i < 3; i++) begin
      alu_carry = ~alu_carry; alu_zero = ~alu_zero;
      step();
      push("flag_hold", 8'h22, 8'h22, 1'b1, 1'b1);
      observe();
    end
    flag_op = 2'b01; alu_carry = 1'b1; alu_zero = 1'b0;
    step();
    idle();
    push("flag_load_c1z0", 8'h22, 8'h22, 1'b1, 1'b0);
    observe();

    // Flag update and write in the same cycle
    flag_op = 2'b10; wr_en = 1'b1; wr_addr = 3'd6; wr_data = 8'h3C;
    ra_addr = 3'd6; rb_addr = 3'd3;
    step();
    idle();
    push("wr_and_flag", 8'h3C, 8'hE5, 1'b0, 1'b0);
    observe();

    // Reset mid-operation
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'hAA; flag_op = 2'b11;
    ra_addr = 3'd4; rb_addr = 3'd6;
    step();
    idle();
    push("pre_reset", 8'hAA, 8'h3C, 1'b1, 1'b0);
    observe();
    #2;
    rst_n = 1'b0;
    push("async_reset", 8'h00, 8'h00, 1'b0, 1'b0);
    observe();
    @(negedge clk);
    rst_n = 1'b1;
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h55; flag_op = 2'b11;
    step();
    push("release_discard", 8'h00, 8'h00, 1'b0, 1'b0);
    observe();
    step();
    idle();
    push("post_release_wr", 8'h55, 8'h00, 1'b1, 1'b0);
    observe();

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_operand_file.md
Name: alu_operand_file

Overview:
- Architectural register file plus carry/zero flag register, directly upstream of the 8-bit ALU.
- Two read ports drive the ALU A and B operands.
- One write port captures the ALU result R.
- The flag register captures the ALU zero and carry_out, and feeds the stored carry back to the ALU carry_in for multi-byte add/subtract chains.

Parameters:
- WIDTH, 8, data width; matches ALU operand/result width.
- NREGS, 8, number of registers.
- AW, 3, address width; must satisfy 2**AW == NREGS.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ra_addr  in  AW  read address for port A.
- rb_addr  in  AW  read address for port B.
- a_data  out  WIDTH  port A read data; drives ALU A.
- b_data  out  WIDTH  port B read data; drives ALU B.
- wr_en  in  1  write enable.
- wr_addr  in  AW  write address.
- wr_data  in  WIDTH  write data; driven by ALU R.
- flag_op  in  2  flag update: 00 hold, 01 load from ALU, 10 clear carry, 11 set carry.
- alu_zero  in  1  ALU zero output.
- alu_carry  in  1  ALU carry_out.
- carry_flag  out  1  stored carry; drives ALU carry_in.
- zero_flag  out  1  stored zero flag.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, no clock needed):
  - all registers clear to 0.
  - carry_flag=0, zero_flag=0.
  - a_data and b_data therefore read 0 while reset is held.
- Reset asserted mid-operation: all state clears immediately. A write or flag update coinciding with the reset-release edge is discarded.
- Register 0 is hardwired to 0:
  - writes to address 0 are ignored.
  - reads of address 0 always return 0.
- Read ports:
  - purely combinational from stored state, ra_addr -> a_data, rb_addr -> b_data.
  - no write-through bypass. ALU R feeds wr_data, so a bypass would create a combinational loop.
- Write:
  - at rising clk, if wr_en=1 and wr_addr!=0, then reg[wr_addr] <= wr_data.
  - the new value is visible on the read ports from the cycle after that edge.
  - a read of the address being written in the same cycle returns the old value.
- Both read ports may address the same register at once; both return the same value.
- Flags, updated at rising clk by flag_op:
  - 00: both flags hold.
  - 01: carry_flag <= alu_carry and zero_flag <= alu_zero, simultaneously.
  - 10: carry_flag <= 0; zero_flag holds.
  - 11: carry_flag <= 1; zero_flag holds.
- Flag update and register write are independent and may occur in the same cycle.
- Latency: write-to-read 1 cycle; flag-to-carry_in 1 cycle.
- No X on any output after reset, including for unwritten registers.

Decomposition:
- Shared package alu_pkg holds:
  - WIDTH and AW constants.
  - flag_op encodings: FLAG_HOLD=2'b00, FLAG_LOAD=2'b01, FLAG_CLR_C=2'b10, FLAG_SET_C=2'b11.
- One natural sub-module, alu_flag_reg: the 2-bit flag register plus flag_op decode, shared with any future status logic.
- The register array and read muxes stay in the top level.

Test Plan:
- Reset: hold rst_n=0 mid-cycle, then release -> a_data=b_data=8'h00 for every address; carry_flag=0, zero_flag=0.
- Write/read: write 8'hE5 to r3 and 8'hC7 to r5, then read ra=3, rb=5 -> a_data=8'hE5, b_data=8'hC7 the cycle after each write, never in the same cycle.
- r0 protection: write 8'hFF to address 0 -> a_data remains 8'h00 at ra_addr=0.
- Read-during-write: r2=8'h11, write 8'h22 to r2 with ra_addr=2 -> a_data=8'h11 before the edge, 8'h22 after; both ports on r2 match.
- Flags: flag_op=01 with alu_carry=1, alu_zero=0 -> carry_flag=1, zero_flag=0. Then flag_op=10 -> carry_flag=0 with zero_flag held. Then flag_op=11 -> carry_flag=1. Then flag_op=00 with inputs toggling -> flags unchanged.
- Reset mid-operation: r4=8'hAA and carry_flag=1, assert rst_n=0 between edges -> r4 and carry_flag read 0 immediately; a write with wr_en=1 on the release edge is discarded.
